// File: rtl/rv32i_regfile_pkg.sv
// Shared definitions for the RV32I architectural register file.
//   REG_COUNT  : number of architectural registers (x0..x31)
//   REG_ADDR_W : width of a register index
//   reg_addr_t : register index type used by the decoder and read ports
package rv32i_regfile_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder_5x32.sv
// 5-to-32 one-hot decoder driving the register file write enables.
// Ports:
//   i_en     : decode enable; all outputs are 0 when low
//   i_addr   : register index to decode
//   o_onehot : one-hot enable vector, bit k set when i_en and i_addr == k
module decoder_5x32
    import rv32i_regfile_pkg::*;
(
    input  logic                 i_en,
    input  reg_addr_t            i_addr,
    output logic [REG_COUNT-1:0] o_onehot
);

    always_comb begin
        o_onehot         = '0;
        o_onehot[i_addr] = i_en;
    end

endmodule

// File: rtl/regfile_wr_demux.sv
// RV32I architectural register file: one synchronous write port, two
// combinational read ports with optional same-cycle write bypass.
// x0 has no storage and always reads 0.
// Ports:
//   i_clk      : clock, state updates on the rising edge
//   i_rst_n    : synchronous active-low reset, clears x1..x31
//   i_wr_en    : write request
//   i_rd_addr  : write destination index
//   i_rd_data  : write data
//   i_rs1_addr : read port 1 index
//   i_rs2_addr : read port 2 index
//   o_rs1_data : read port 1 data
//   o_rs2_data : read port 2 data
module regfile_wr_demux
    import rv32i_regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  reg_addr_t        i_rd_addr,
    input  logic [WIDTH-1:0] i_rd_data,
    input  reg_addr_t        i_rs1_addr,
    input  reg_addr_t        i_rs2_addr,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data
);

    logic [REG_COUNT-1:0] dec_onehot;
    logic [REG_COUNT-1:0] wr_vec;
    logic [WIDTH-1:0]     regs   [1:REG_COUNT-1];
    logic [WIDTH-1:0]     mux_in [REG_COUNT];
    logic [WIDTH-1:0]     rs1_stored;
    logic [WIDTH-1:0]     rs2_stored;
    logic                 rs1_hit;
    logic                 rs2_hit;

    // Reset gates the decoder so a write in the reset cycle never lands.
    decoder_5x32 u_wr_dec (
        .i_en     (i_wr_en & i_rst_n),
        .i_addr   (i_rd_addr),
        .o_onehot (dec_onehot)
    );

    // x0 has no storage; its enable is dropped.
    assign wr_vec = {dec_onehot[REG_COUNT-1:1], 1'b0};

    always_ff @(posedge i_clk) begin
        for (int unsigned k = 1; k < REG_COUNT; k++) begin
            if (!i_rst_n) begin
                regs[k] <= '0;
            end else if (wr_vec[reg_addr_t'(k)]) begin
                regs[k] <= i_rd_data;
            end
        end
    end

    // 32:1 read select with x0 tied to zero.
    always_comb begin
        mux_in[0] = '0;
        for (int unsigned k = 1; k < REG_COUNT; k++) begin
            mux_in[k] = regs[k];
        end
    end

    assign rs1_stored = mux_in[i_rs1_addr];
    assign rs2_stored = mux_in[i_rs2_addr];

    // Bypass hit also requires a nonzero index so x0 writes never forward.
    assign rs1_hit = BYPASS && i_wr_en && (i_rd_addr == i_rs1_addr) && (i_rs1_addr != '0);
    assign rs2_hit = BYPASS && i_wr_en && (i_rd_addr == i_rs2_addr) && (i_rs2_addr != '0);

    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if (i_rst_n) begin
            o_rs1_data = rs1_hit ? i_rd_data : rs1_stored;
            o_rs2_data = rs2_hit ? i_rd_data : rs2_stored;
        end
    end

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Self-checking bench for regfile_wr_demux. Two instances share every input:
// one with bypass enabled, one without. Expected values come from an array
// model of the architectural register file updated at each rising edge.
module tb_regfile_wr_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] byp_rs1, byp_rs2;
    logic [31:0] nb_rs1, nb_rs2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_wr_demux #(.WIDTH(32), .BYPASS(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(byp_rs1), .o_rs2_data(byp_rs2)
    );

    regfile_wr_demux #(.WIDTH(32), .BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(nb_rs1), .o_rs2_data(nb_rs2)
    );

    // Architectural read as seen by software: reset and x0 read zero,
    // a pending write is visible only through bypass.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rst_n)                            return 32'h0;
        if (a == 5'd0)                         return 32'h0;
        if (byp && wr_en && rd_addr == a)      return rd_data;
        return model[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        rst_n = rst; wr_en = we; rd_addr = wa; rd_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        #1;
    endtask

    // One rising edge; the model follows the architectural write rule.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wr_en && rd_addr != 5'd0) begin
            model[rd_addr] = rd_data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || byp_rs2 !== 32'h0) begin
            n_err++; $display("FAIL reset_hold_byp got %h/%h want 0/0", byp_rs1, byp_rs2);
        end
        n_cmp++;
        if (nb_rs1 !== 32'h0 || nb_rs2 !== 32'h0) begin
            n_err++; $display("FAIL reset_hold_nb got %h/%h want 0/0", nb_rs1, nb_rs2);
        end
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || nb_rs1 !== 32'h0) begin
            n_err++; $display("FAIL reset_clear x5 got %h/%h want 0", byp_rs1, nb_rs1);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || nb_rs1 !== 32'h0) begin
            n_err++; $display("FAIL x0_same_cycle got %h/%h want 0", byp_rs1, nb_rs1);
        end
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || nb_rs1 !== 32'h0) begin
            n_err++; $display("FAIL x0_next_cycle got %h/%h want 0", byp_rs1, nb_rs1);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2);
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        n_cmp++;
        if (byp_rs1 !== 32'h12345678 || byp_rs2 !== 32'h12345678) begin
            n_err++; $display("FAIL basic_byp got %h/%h want 12345678", byp_rs1, byp_rs2);
        end
        n_cmp++;
        if (nb_rs1 !== 32'h12345678 || nb_rs2 !== 32'h12345678) begin
            n_err++; $display("FAIL basic_nb got %h/%h want 12345678", nb_rs1, nb_rs2);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h22222222, 5'd0, 5'd3);
        n_cmp++;
        if (byp_rs2 !== 32'h22222222) begin
            n_err++; $display("FAIL bypass_on got %h want 22222222", byp_rs2);
        end
        n_cmp++;
        if (nb_rs2 !== 32'h11111111) begin
            n_err++; $display("FAIL bypass_off_same got %h want 11111111", nb_rs2);
        end
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
        n_cmp++;
        if (nb_rs2 !== 32'h22222222) begin
            n_err++; $display("FAIL bypass_off_next got %h want 22222222", nb_rs2);
        end
    endtask

    task automatic test_reset_collision();
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || nb_rs2 !== 32'h0) begin
            n_err++; $display("FAIL collision_hold got %h/%h want 0", byp_rs1, nb_rs2);
        end
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        n_cmp++;
        if (byp_rs1 !== 32'h0 || nb_rs1 !== 32'h0) begin
            n_err++; $display("FAIL collision_x9 got %h/%h want 0", byp_rs1, nb_rs1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 32'hC0DE0000 + 32'(i);
            drive(1'b1, 1'b1, 5'd12, v, 5'd12, 5'd12);
            n_cmp++;
            if (byp_rs1 !== v) begin
                n_err++; $display("FAIL b2b_bypass[%0d] got %h want %h", i, byp_rs1, v);
            end
            tick();
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        n_cmp++;
        if (byp_rs2 !== 32'hC0DE0003 || nb_rs2 !== 32'hC0DE0003) begin
            n_err++; $display("FAIL b2b_last got %h/%h want c0de0003", byp_rs2, nb_rs2);
        end
    endtask

    task automatic test_exhaustive();
        logic [31:0] w1, w2;
        for (int k = 1; k < 32; k++) begin
            drive(1'b1, 1'b1, 5'(k), 32'(k) * 32'h01010101, 5'd0, 5'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(j));
                w1 = 32'(i) * 32'h01010101;
                w2 = 32'(j) * 32'h01010101;
                n_cmp++;
                if (byp_rs1 !== w1 || byp_rs2 !== w2 || nb_rs1 !== w1 || nb_rs2 !== w2) begin
                    n_err++;
                    $display("FAIL exhaustive rs1=%0d rs2=%0d got %h %h %h %h want %h %h",
                             i, j, byp_rs1, byp_rs2, nb_rs1, nb_rs2, w1, w2);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1b, e2b, e1n, e2n;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) >= 4), 1'($urandom), 5'($urandom),
                  $urandom, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                rs1_addr = rd_addr;
                #1;
            end
            e1b = exp_rd(rs1_addr, 1'b1);
            e2b = exp_rd(rs2_addr, 1'b1);
            e1n = exp_rd(rs1_addr, 1'b0);
            e2n = exp_rd(rs2_addr, 1'b0);
            n_cmp++;
            if (byp_rs1 !== e1b || byp_rs2 !== e2b || nb_rs1 !== e1n || nb_rs2 !== e2n) begin
                n_err++;
                $display("FAIL random[%0d] got %h %h %h %h want %h %h %h %h",
                         c, byp_rs1, byp_rs2, nb_rs1, nb_rs2, e1b, e2b, e1n, e2n);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        test_reset();
        test_x0();
        test_basic();
        test_bypass();
        test_reset_collision();
        test_back_to_back();
        test_exhaustive();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
